// File: rtl/mips_cpu_pc_unit.sv
// Program counter and fetch sequencer for the Harvard MIPS core.
// Handles branch delay slots, stall hold, misaligned redirect
// targets and the jump-to-zero halt.
module mips_cpu_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    output logic [31:0] pc_plus8,
    output logic        in_delay_slot,
    output logic        active,
    output logic        fetch_exception
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DELAY = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic [31:0] pending, pending_n;
    logic        active_n;
    logic        ds_n;
    logic        exc_n;
    logic        adv;

    // The machine only moves when enabled, not stalled and not halted;
    // reset is handled separately in the register process.
    assign adv = clk_enable && !stall && (state != HALT);

    // Link value for JAL/JALR/BxxAL, derived from the PC register only.
    assign pc_plus8 = instr_address + 32'd8;

    // State register: reset wins over everything, otherwise load next values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= RUN;
            instr_address   <= RESET_VECTOR;
            pending         <= 32'd0;
            active          <= 1'b1;
            in_delay_slot   <= 1'b0;
            fetch_exception <= 1'b0;
        end else begin
            state           <= state_n;
            instr_address   <= pc_n;
            pending         <= pending_n;
            active          <= active_n;
            in_delay_slot   <= ds_n;
            fetch_exception <= exc_n;
        end
    end

    // Next-state logic: hold by default, step only on an advance.
    always_comb begin
        state_n   = state;
        pc_n      = instr_address;
        pending_n = pending;
        active_n  = active;
        ds_n      = in_delay_slot;
        exc_n     = fetch_exception;
        if (adv) begin
            case (state)
                RUN: begin
                    if (!redirect_valid) begin
                        pc_n = instr_address + 32'd4;
                    end else if (redirect_target[1:0] == 2'b00) begin
                        // Fetch the delay slot first; the target waits in pending.
                        pending_n = redirect_target;
                        pc_n      = instr_address + 32'd4;
                        state_n   = DELAY;
                        ds_n      = 1'b1;
                    end else begin
                        exc_n    = 1'b1;
                        active_n = 1'b0;
                        pc_n     = HALT_ADDRESS;
                        state_n  = HALT;
                    end
                end
                DELAY: begin
                    // A branch sitting in the delay slot is ignored.
                    ds_n = 1'b0;
                    if (pending == HALT_ADDRESS) begin
                        pc_n     = HALT_ADDRESS;
                        active_n = 1'b0;
                        state_n  = HALT;
                    end else begin
                        pc_n    = pending;
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Scoreboard bench for mips_cpu_pc_unit: directed scenarios followed by
// randomized traffic, checked against a behavioural fetch model.
module tb_mips_cpu_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] instr_address;
    logic [31:0] pc_plus8;
    logic        in_delay_slot;
    logic        active;
    logic        fetch_exception;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p8;
        logic        ds;
        logic        act;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_act, m_ds, m_exc, m_halted;
    logic [31:0] branch_q[$];

    mips_cpu_pc_unit dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .instr_address(instr_address),
        .pc_plus8(pc_plus8),
        .in_delay_slot(in_delay_slot),
        .active(active),
        .fetch_exception(fetch_exception)
    );

    always #5 clk = ~clk;

    // Model one clock edge with the given inputs and queue the expectation.
    task automatic step(input logic r, input logic e, input logic s,
                        input logic rv, input logic [31:0] rt);
        exp_t x;
        @(negedge clk);
        #1;
        reset = r; clk_enable = e; stall = s;
        redirect_valid = rv; redirect_target = rt;
        if (!r) begin
            m_pc = 32'hBFC00000; m_act = 1; m_ds = 0; m_exc = 0; m_halted = 0;
            branch_q.delete();
        end else if (e && !s && !m_halted) begin
            if (branch_q.size() > 0) begin
                logic [31:0] t;
                t = branch_q.pop_front();
                m_ds = 0;
                if (t == 32'd0) begin
                    m_pc = 0; m_act = 0; m_halted = 1;
                end else begin
                    m_pc = t;
                end
            end else if (rv && (rt % 4 != 0)) begin
                m_exc = 1; m_act = 0; m_pc = 0; m_halted = 1;
            end else if (rv) begin
                branch_q.push_back(rt);
                m_pc = m_pc + 4;
                m_ds = 1;
            end else begin
                m_pc = m_pc + 4;
            end
        end
        x.pc = m_pc; x.p8 = m_pc + 8; x.ds = m_ds; x.act = m_act; x.exc = m_exc;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
    endtask

    // Monitor: one expectation per edge, compared just after that edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (instr_address !== x.pc) begin
                    errors++;
                    $display("FAIL instr_address t=%0t got=%h exp=%h", $time, instr_address, x.pc);
                end
                checks++;
                if (pc_plus8 !== x.p8) begin
                    errors++;
                    $display("FAIL pc_plus8 t=%0t got=%h exp=%h", $time, pc_plus8, x.p8);
                end
                checks++;
                if (in_delay_slot !== x.ds) begin
                    errors++;
                    $display("FAIL in_delay_slot t=%0t got=%b exp=%b", $time, in_delay_slot, x.ds);
                end
                checks++;
                if (active !== x.act) begin
                    errors++;
                    $display("FAIL active t=%0t got=%b exp=%b", $time, active, x.act);
                end
                checks++;
                if (fetch_exception !== x.exc) begin
                    errors++;
                    $display("FAIL fetch_exception t=%0t got=%b exp=%b", $time, fetch_exception, x.exc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and plain sequential fetch
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        run(4);

        // JR to 0 from BFC00008: delay slot then halt; frozen afterwards
        step(0, 1, 0, 0, 0);
        run(2);
        step(1, 1, 0, 1, 32'h0);
        run(1);
        for (int i = 0; i < 10; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, $urandom);

        // Branch with stall inside the delay slot
        step(0, 1, 0, 0, 0);
        run(1);
        step(1, 1, 0, 1, 32'hBFC00100);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 32'hBFC00100);
        step(1, 1, 0, 0, 0);
        run(2);

        // Misaligned target
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'hBFC00102);
        run(3);

        // Reset while in the delay slot discards the pending target
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'hBFC00200);
        step(0, 1, 0, 0, 0);
        run(3);

        // clk_enable low mid-run
        step(0, 1, 0, 0, 0);
        run(4);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 32'hBFC00300);
        run(2);

        // Sequential wrap past the top of memory stays active
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'hFFFFFFF8);
        run(5);

        // Randomized traffic
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic        r, e, s, rv;
            logic [31:0] rt;
            int          k;
            r  = ($urandom_range(0, 39) != 0);
            e  = ($urandom_range(0, 7) != 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 4) == 0);
            k  = $urandom_range(0, 9);
            rt = $urandom;
            if (k == 0) rt = 32'd0;
            else if (k < 8) rt[1:0] = 2'b00;
            step(r, e, s, rv, rt);
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
